// File: rtl/spi_source_emitter.sv
`default_nettype none
// ============================================================================
// Module      : spi_source_emitter
// Description : Buffers 16-bit words in a FIFO and emits them MSB-first on a
//               divided serial clock with word (LOAD) and message (STOP)
//               strobes. Define SPI_PARITY_EN to append an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_source_emitter #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] WR_DATA,
    input  logic        WR_EN,
    input  logic        MSG_END,
    output logic        FULL,
    output logic        OVF,
    output logic        BUSY,
    output logic        SPI_CLK,
    output logic        SPI_DATA,
    output logic        SPI_LOAD,
    output logic        SPI_STOP
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
`ifdef SPI_PARITY_EN
    localparam int c_NBITS = 17;
`else
    localparam int c_NBITS = 16;
`endif
    localparam logic [4:0]    c_LAST_BIT = 5'(c_NBITS - 1);
    localparam logic [7:0]    c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]    c_DIV_PRE  = 8'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);
    localparam logic [c_AW:0] c_PTR_ONE  = (c_AW + 1)'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD_W = 2'd1;
    localparam logic [1:0] c_SHIFT  = 2'd2;
    localparam logic [1:0] c_GAP    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [16:0]        mem_q [FIFO_DEPTH];
    logic [c_AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               full_q, full_d, ovf_q, ovf_d, busy_q, busy_d;
    logic [7:0]         div_q, div_d;
    logic               phase_q, phase_d;
    logic [4:0]         bit_q, bit_d;
    logic [c_NBITS-1:0] shift_q, shift_d;
    logic               end_q, end_d;
    logic               spi_clk_q, spi_clk_d, spi_data_q, spi_data_d;
    logic               spi_load_q, spi_load_d, spi_stop_q, spi_stop_d;

    logic               w_push, w_pop, w_empty, w_bit_end, w_gap_pre;
    logic [16:0]        w_head;
    logic [c_NBITS-1:0] w_load_word;

    // FULL is the registered flag, so a write in a full cycle is lost even if a pop happens
    assign w_push  = WR_EN && !full_q;
    assign w_pop   = (state_q == c_LOAD_W);
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_head  = mem_q[rd_ptr_q[c_AW-1:0]];

`ifdef SPI_PARITY_EN
    assign w_load_word = {w_head[15:0], ^w_head[15:0]};
`else
    assign w_load_word = w_head[15:0];
`endif

    assign w_bit_end = phase_q && (div_q == c_DIV_LAST);
    // LOAD_W occupies the final gap cycle so back-to-back words see exactly one idle bit period
    assign w_gap_pre = (CLK_DIV == 1) ? !phase_q : (phase_q && (div_q == c_DIV_PRE));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= c_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (!w_empty) state_d = c_LOAD_W;
            c_LOAD_W: state_d = c_SHIFT;
            c_SHIFT:  if (w_bit_end && (bit_q == c_LAST_BIT)) state_d = c_GAP;
            c_GAP: begin
                if (w_gap_pre && !w_empty) state_d = c_LOAD_W;
                else if (w_bit_end)        state_d = c_IDLE;
            end
            default:  state_d = c_IDLE;
        endcase
    end

    always_comb begin
        spi_clk_d  = 1'b0;
        spi_data_d = 1'b0;
        spi_load_d = 1'b0;
        spi_stop_d = 1'b0;
        if (state_q == c_SHIFT) begin
            spi_clk_d  = phase_q;
            spi_data_d = shift_q[c_NBITS-1];
            spi_load_d = (bit_q == c_LAST_BIT);
            spi_stop_d = (bit_q == c_LAST_BIT) && end_q;
        end
        busy_d = (state_q != c_IDLE) || !w_empty;
    end

    always_comb begin
        wr_ptr_d = w_push ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;
        full_d   = (wr_ptr_d[c_AW] != rd_ptr_d[c_AW]) &&
                   (wr_ptr_d[c_AW-1:0] == rd_ptr_d[c_AW-1:0]);
        ovf_d    = ovf_q || (WR_EN && full_q);

        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        end_d   = end_q;
        case (state_q)
            c_LOAD_W: begin
                shift_d = w_load_word;
                end_d   = w_head[16];
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
            end
            c_SHIFT, c_GAP: begin
                if (div_q == c_DIV_LAST) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[c_NBITS-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                div_d   = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) mem_q[wr_ptr_q[c_AW-1:0]] <= {MSG_END, WR_DATA};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            div_q      <= '0;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            shift_q    <= '0;
            end_q      <= 1'b0;
            spi_clk_q  <= 1'b0;
            spi_data_q <= 1'b0;
            spi_load_q <= 1'b0;
            spi_stop_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            end_q      <= end_d;
            spi_clk_q  <= spi_clk_d;
            spi_data_q <= spi_data_d;
            spi_load_q <= spi_load_d;
            spi_stop_q <= spi_stop_d;
        end
    end

    assign FULL     = full_q;
    assign OVF      = ovf_q;
    assign BUSY     = busy_q;
    assign SPI_CLK  = spi_clk_q;
    assign SPI_DATA = spi_data_q;
    assign SPI_LOAD = spi_load_q;
    assign SPI_STOP = spi_stop_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_source_emitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_source_emitter
// Description : Directed bench for spi_source_emitter; a serial decoder pops
//               expected words from a scoreboard queue as they complete.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_source_emitter;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 16;
`ifdef SPI_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        msg_end = 1'b0;
    logic        full, ovf, busy, spi_clk, spi_data, spi_load, spi_stop;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          words_rx = 0;
    int          nbits = 0;
    int          last_bits = 0;
    logic [16:0] acc = '0;
    logic [16:0] last_word = '0;
    logic        prev_clk = 1'b0;
    logic        prev_data = 1'b0;
    logic [17:0] mon_e;
    logic [17:0] exp_q [$];

    spi_source_emitter #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(clk), .RST(rst), .WR_DATA(wr_data), .WR_EN(wr_en), .MSG_END(msg_end),
        .FULL(full), .OVF(ovf), .BUSY(busy), .SPI_CLK(spi_clk), .SPI_DATA(spi_data),
        .SPI_LOAD(spi_load), .SPI_STOP(spi_stop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] exp_word(input logic [15:0] d, input logic e);
        logic [16:0] v;
        if (NB == 17) v = {d, ^d};
        else          v = {1'b0, d};
        return {e, v};
    endfunction

    // Assert WR_EN for the coming rising edge; the caller deasserts with idle()
    task automatic drive(input logic [15:0] d, input logic e, input logic accept);
        @(negedge clk);
        wr_data = d;
        msg_end = e;
        wr_en   = 1'b1;
        if (accept) exp_q.push_back(exp_word(d, e));
    endtask

    task automatic idle();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Serial decoder: shift on each SPI_CLK rise, close a word when LOAD is seen
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                nbits     = 0;
                acc       = '0;
                prev_clk  = 1'b0;
                prev_data = 1'b0;
            end else begin
                if (spi_data !== prev_data) check("data_changes_in_low_phase", spi_clk, 0);
                if (spi_clk && !prev_clk) begin
                    acc = {acc[15:0], spi_data};
                    nbits++;
                    if (spi_load) begin
                        words_rx++;
                        last_word = acc;
                        last_bits = nbits;
                        check("word_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            mon_e = exp_q.pop_front();
                            check("word_bits", nbits, NB);
                            check("word_value", acc, mon_e[16:0]);
                            check("word_stop", spi_stop, mon_e[17]);
                        end
                        nbits = 0;
                        acc   = '0;
                    end else begin
                        check("stop_without_load", spi_stop, 0);
                    end
                end
                prev_clk  = spi_clk;
                prev_data = spi_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int rx0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_spi_clk", spi_clk, 0);
        check("rst_spi_data", spi_data, 0);
        check("rst_spi_load", spi_load, 0);
        check("rst_spi_stop", spi_stop, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word with message end: latency and BUSY duration
        drive(16'hA5C3, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        @(negedge clk);
        check("latency_before_bit15", spi_data, 0);
        @(negedge clk);
        check("latency_bit15", spi_data, 1);
        check("latency_clk_low", spi_clk, 0);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_len", n, NB * 2 * CLK_DIV + 2 * CLK_DIV);
        drain("drain_single");

        // Back-to-back words: gap between them
        drive(16'h1234, 1'b0, 1'b1);
        drive(16'hFFFF, 1'b1, 1'b1);
        idle();
        n = 0;
        while (!spi_load && n < 500) begin @(negedge clk); n++; end
        while (spi_load && n < 500) begin @(negedge clk); n++; end
        n = 0;
        while (!spi_data && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("gap_cycles", n, 2 * CLK_DIV);
        drain("drain_b2b");

        // Overflow while the first word is in flight
        rx0 = words_rx;
        drive(16'h0F0F, 1'b0, 1'b1);
        idle();
        n = 0;
        while (!spi_clk && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            wr_data = 16'h1000 + 16'(i * 16'h0111);
            msg_end = (i == 15);
            wr_en   = 1'b1;
            if (i < 16) exp_q.push_back(exp_word(wr_data, msg_end));
            @(negedge clk);
            if (i == 14) check("full_after_15", full, 0);
            if (i == 15) begin
                check("full_after_16", full, 1);
                check("ovf_before_17", ovf, 0);
            end
        end
        wr_en = 1'b0;
        check("ovf_after_17", ovf, 1);
        check("full_after_17", full, 1);
        drain("drain_overflow");
        check("overflow_words_sent", words_rx - rx0, 17);
        check("ovf_sticky", ovf, 1);
        check("full_cleared", full, 0);

        // Reset in the middle of a word
        drive(16'h00FF, 1'b1, 1'b1);
        idle();
        n = 0;
        while (nbits < 8 && n < 500) begin @(negedge clk); n++; end
        check("abort_point", nbits, 8);
        rx0 = words_rx;
        #1 rst = 1'b1;
        #1;
        check("abort_spi_clk", spi_clk, 0);
        check("abort_spi_data", spi_data, 0);
        check("abort_spi_load", spi_load, 0);
        check("abort_spi_stop", spi_stop, 0);
        check("abort_busy", busy, 0);
        check("abort_ovf", ovf, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_word", words_rx - rx0, 0);
        check("abort_idle", busy, 0);
        drive(16'h8001, 1'b1, 1'b1);
        idle();
        drain("drain_after_reset");
        check("after_reset_word", last_word[15:0] & 16'hFFFF, (NB == 17) ? 16'h0002 : 16'h8001);
        check("after_reset_count", words_rx - rx0, 1);

`ifdef SPI_PARITY_EN
        // Parity bit carries the LOAD strobe
        drive(16'h0007, 1'b1, 1'b1);
        idle();
        drain("drain_parity");
        check("parity_bits", last_bits, 17);
        check("parity_bit", last_word[0], 1);
        check("parity_data", last_word[16:1], 16'h0007);
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
